// File: rtl/mmu_pager_pkg.sv
// Shared constants for the mmu_pager slice: register offsets, CTRL/STATUS bit
// positions and the wait-state FSM encoding.
package mmu_pager_pkg;

    localparam logic [4:0] OFF_ENABLE  = 5'd8;
    localparam logic [4:0] OFF_WPROT   = 5'd9;
    localparam logic [4:0] OFF_CTRL    = 5'd10;
    localparam logic [4:0] OFF_STATUS  = 5'd11;
    localparam logic [4:0] OFF_FADDR_H = 5'd12;
    localparam logic [4:0] OFF_FADDR_L = 5'd13;

    localparam int CTRL_BRAM_BIT    = 0;
    localparam int CTRL_IRQEN_BIT   = 1;
    localparam int CTRL_WS_LSB      = 4;
    localparam int STATUS_FAULT_BIT = 0;
    localparam int STATUS_BUSY_BIT  = 7;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } wait_state_t;

endpackage

// File: rtl/mmu_wait_gen.sv
// Wait-state generator: stretches each external access by ws cycles by holding
// the CPU, using a small IDLE/WAIT FSM and a 4-bit down counter.
module mmu_wait_gen
    import mmu_pager_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] ws,
    output logic       hold,
    output logic       busy
);

    wait_state_t state, state_next;
    logic [3:0]  cnt, cnt_next;

    // State and counter registers; reset forces IDLE so hold drops at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Next-state, counter and hold decode; the first hold cycle comes from IDLE.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        hold       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start && (ws != 4'd0)) begin
                    hold       = 1'b1;
                    state_next = ST_WAIT;
                    cnt_next   = ws - 4'd1;
                end
            end
            ST_WAIT: begin
                if (cnt != 4'd0) begin
                    hold     = 1'b1;
                    cnt_next = cnt - 4'd1;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign busy = (state == ST_WAIT);

endmodule

// File: rtl/mmu_pager.sv
// Multi-window memory pager for the 6801 bus: per-window page translation,
// write protection with first-fault address capture, and wait-state stretching.
module mmu_pager
    import mmu_pager_pkg::*;
#(
    parameter int WINDOWS    = 2,
    parameter int FIRST_SLOT = 2,
    parameter int PAGE_BITS  = 3,
    parameter int WS_RESET   = 0,
    parameter int EXT_AW     = PAGE_BITS + 14
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [15:0]       AD,
    input  logic [7:0]        DI,
    output logic [7:0]        DO,
    input  logic              rw,
    input  logic              vma,
    input  logic              cs,
    input  logic              ext_sel,
    output logic [EXT_AW-1:0] ext_addr,
    output logic              ext_we_ok,
    output logic              bram_disable,
    output logic              hold,
    output logic              irq
);

    logic [PAGE_BITS-1:0] page_q [WINDOWS];
    logic [WINDOWS-1:0]   enable_q;
    logic [WINDOWS-1:0]   wprot_q;
    logic                 bram_q;
    logic                 irq_en_q;
    logic [3:0]           ws_q;
    logic                 fault_q;
    logic [15:0]          faddr_q;
    logic [WINDOWS-1:0]   hit;
    logic                 reg_wr;
    logic                 prot_hit;
    logic                 busy;
    logic [4:0]           off;
    logic                 unused_di;

    assign off       = AD[4:0];
    assign reg_wr    = cs && !rw;
    assign unused_di = ^DI[3:2];

    // Window hit decode against the current enable bits.
    always_comb begin
        for (int i = 0; i < WINDOWS; i++) begin
            hit[i] = enable_q[i] && (AD[15:13] == 3'(FIRST_SLOT + i));
        end
    end

    assign prot_hit  = vma && !rw && ((hit & wprot_q) != '0);
    assign ext_we_ok = !prot_hit;

    // Address translation; slots are distinct so at most one window hits.
    always_comb begin
        ext_addr       = '0;
        ext_addr[15:0] = AD;
        for (int i = 0; i < WINDOWS; i++) begin
            if (hit[i]) begin
                ext_addr = {1'b1, page_q[i], AD[12:0]};
            end
        end
    end

    // Programmable registers, written by CPU stores to the register block.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < WINDOWS; i++) page_q[i] <= '0;
            enable_q <= '0;
            wprot_q  <= '0;
            bram_q   <= 1'b0;
            irq_en_q <= 1'b0;
            ws_q     <= 4'(WS_RESET);
        end else if (reg_wr) begin
            for (int i = 0; i < WINDOWS; i++) begin
                if (off == 5'(i)) page_q[i] <= DI[PAGE_BITS-1:0];
            end
            if (off == OFF_ENABLE) enable_q <= DI[WINDOWS-1:0];
            if (off == OFF_WPROT)  wprot_q  <= DI[WINDOWS-1:0];
            if (off == OFF_CTRL) begin
                bram_q   <= DI[CTRL_BRAM_BIT];
                irq_en_q <= DI[CTRL_IRQEN_BIT];
                ws_q     <= DI[CTRL_WS_LSB +: 4];
            end
        end
    end

    // Fault flag and first-fault address; a new fault beats a same-edge clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fault_q <= 1'b0;
            faddr_q <= 16'h0000;
        end else begin
            if (prot_hit) begin
                fault_q <= 1'b1;
                if (!fault_q) faddr_q <= AD;
            end else if (reg_wr && (off == OFF_STATUS) && DI[STATUS_FAULT_BIT]) begin
                fault_q <= 1'b0;
            end
        end
    end

    // Register read-back; unimplemented offsets float high.
    always_comb begin
        DO = 8'hFF;
        for (int i = 0; i < WINDOWS; i++) begin
            if (off == 5'(i)) begin
                DO = 8'h00;
                DO[PAGE_BITS-1:0] = page_q[i];
            end
        end
        case (off)
            OFF_ENABLE: begin
                DO = 8'h00;
                DO[WINDOWS-1:0] = enable_q;
            end
            OFF_WPROT: begin
                DO = 8'h00;
                DO[WINDOWS-1:0] = wprot_q;
            end
            OFF_CTRL:    DO = {ws_q, 2'b00, irq_en_q, bram_q};
            OFF_STATUS:  DO = {busy, 6'b000000, fault_q};
            OFF_FADDR_H: DO = faddr_q[15:8];
            OFF_FADDR_L: DO = faddr_q[7:0];
            default: ;
        endcase
    end

    assign bram_disable = bram_q;
    assign irq          = fault_q && irq_en_q;

    mmu_wait_gen u_wait_gen (
        .clk   (clk),
        .rst   (rst),
        .start (ext_sel && vma),
        .ws    (ws_q),
        .hold  (hold),
        .busy  (busy)
    );

endmodule

// File: tb/tb_mmu_pager.sv
// Scoreboard bench for mmu_pager: stimulus pushes expected values, a negedge
// monitor pops and compares them against the live outputs.
module tb_mmu_pager;

    localparam int SEL_DO    = 0;
    localparam int SEL_EXTA  = 1;
    localparam int SEL_WEOK  = 2;
    localparam int SEL_HOLD  = 3;
    localparam int SEL_IRQ   = 4;
    localparam int SEL_BRAM  = 5;
    localparam int SEL_EXTB  = 6;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] AD = 16'h0000;
    logic [7:0]  DI = 8'h00;
    logic        rw = 1'b1;
    logic        vma = 1'b0;
    logic        cs = 1'b0;
    logic        ext_sel = 1'b0;

    logic [7:0]  do_a, do_b;
    logic [16:0] ext_addr_a;
    logic [18:0] ext_addr_b;
    logic        we_ok_a, we_ok_b, bram_a, bram_b, hold_a, hold_b, irq_a, irq_b;

    typedef struct {
        string       name;
        int          sel;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   passed = 0;

    always #5 clk = ~clk;

    mmu_pager #(.WINDOWS(2), .FIRST_SLOT(2), .PAGE_BITS(3), .WS_RESET(0)) dut_a (
        .clk(clk), .rst(rst), .AD(AD), .DI(DI), .DO(do_a), .rw(rw), .vma(vma),
        .cs(cs), .ext_sel(ext_sel), .ext_addr(ext_addr_a), .ext_we_ok(we_ok_a),
        .bram_disable(bram_a), .hold(hold_a), .irq(irq_a)
    );

    mmu_pager #(.WINDOWS(4), .FIRST_SLOT(2), .PAGE_BITS(5), .WS_RESET(0)) dut_b (
        .clk(clk), .rst(rst), .AD(AD), .DI(DI), .DO(do_b), .rw(rw), .vma(vma),
        .cs(cs), .ext_sel(ext_sel), .ext_addr(ext_addr_b), .ext_we_ok(we_ok_b),
        .bram_disable(bram_b), .hold(hold_b), .irq(irq_b)
    );

    function automatic logic [31:0] actual(input int sel);
        case (sel)
            SEL_DO:   return 32'(do_a);
            SEL_EXTA: return 32'(ext_addr_a);
            SEL_WEOK: return 32'(we_ok_a);
            SEL_HOLD: return 32'(hold_a);
            SEL_IRQ:  return 32'(irq_a);
            SEL_BRAM: return 32'(bram_a);
            SEL_EXTB: return 32'(ext_addr_b);
            default:  return 32'hDEAD_BEEF;
        endcase
    endfunction

    // Monitor: compare every pending expectation in the middle of the cycle.
    always @(negedge clk) begin
        while (sb.size() > 0) begin
            exp_t e;
            logic [31:0] act;
            e = sb.pop_front();
            act = actual(e.sel);
            checks++;
            if (act === e.exp) passed++;
            else $display("[TB] FAIL %s: got %0h expected %0h", e.name, act, e.exp);
        end
    end

    task automatic applyStimulus(input logic c, input logic v, input logic r,
                                 input logic e, input logic [15:0] a, input logic [7:0] d);
        @(posedge clk);
        #1;
        cs = c; vma = v; rw = r; ext_sel = e; AD = a; DI = d;
    endtask

    task automatic checkOutput(input string name, input int sel, input logic [31:0] exp);
        sb.push_back('{name: name, sel: sel, exp: exp});
    endtask

    task automatic reg_write(input logic [4:0] off, input logic [7:0] d);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 16'hE6E0 + 16'(off), d);
    endtask

    task automatic reg_read(input string name, input logic [4:0] off, input logic [7:0] exp);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 16'hE6E0 + 16'(off), 8'h00);
        checkOutput(name, SEL_DO, 32'(exp));
    endtask

    task automatic bus_idle();
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 8'h00);
    endtask

    initial begin
        // Reset state
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 16'h6123, 8'h00);
        checkOutput("rst_ext_addr", SEL_EXTA, 32'h06123);
        checkOutput("rst_hold", SEL_HOLD, 32'd0);
        checkOutput("rst_irq", SEL_IRQ, 32'd0);
        checkOutput("rst_bram", SEL_BRAM, 32'd0);
        checkOutput("rst_we_ok", SEL_WEOK, 32'd1);
        reg_read("rst_ctrl", 5'd10, 8'h00);
        @(posedge clk);
        #1 rst = 1'b1;

        // Translation
        reg_write(5'd1, 8'h05);
        reg_write(5'd8, 8'h02);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 16'h6123, 8'h00);
        checkOutput("xlat_win1", SEL_EXTA, 32'h1A123);
        checkOutput("xlat_hold", SEL_HOLD, 32'd0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 16'h4123, 8'h00);
        checkOutput("xlat_win0_off", SEL_EXTA, 32'h04123);
        reg_read("page1_rd", 5'd1, 8'h05);
        reg_write(5'd1, 8'hFD);
        reg_read("page1_mask", 5'd1, 8'h05);
        reg_read("enable_rd", 5'd8, 8'h02);

        // Write protection and first-fault capture
        reg_write(5'd9, 8'h02);
        reg_write(5'd10, 8'h02);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 16'h7000, 8'h55);
        checkOutput("prot_we_ok", SEL_WEOK, 32'd0);
        checkOutput("prot_irq_early", SEL_IRQ, 32'd0);
        bus_idle();
        checkOutput("fault_irq", SEL_IRQ, 32'd1);
        reg_read("fault_status", 5'd11, 8'h01);
        reg_read("faddr_hi", 5'd12, 8'h70);
        reg_read("faddr_lo", 5'd13, 8'h00);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 16'h7FFF, 8'h55);
        checkOutput("prot2_we_ok", SEL_WEOK, 32'd0);
        reg_read("faddr_hi_kept", 5'd12, 8'h70);
        reg_read("faddr_lo_kept", 5'd13, 8'h00);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 16'h4000, 8'h55);
        checkOutput("unprot_we_ok", SEL_WEOK, 32'd1);

        // Fault clear, then clear racing a new fault
        reg_write(5'd11, 8'h01);
        bus_idle();
        checkOutput("clear_irq", SEL_IRQ, 32'd0);
        reg_read("clear_status", 5'd11, 8'h00);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 16'h7000, 8'h55);
        bus_idle();
        checkOutput("refault_irq", SEL_IRQ, 32'd1);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 16'h700B, 8'h01);
        checkOutput("race_we_ok", SEL_WEOK, 32'd0);
        bus_idle();
        checkOutput("race_irq", SEL_IRQ, 32'd1);
        reg_read("race_status", 5'd11, 8'h01);
        reg_write(5'd11, 8'h01);
        reg_read("final_clear", 5'd11, 8'h00);

        // WS = 3 stretch with busy visible in STATUS
        reg_write(5'd10, 8'h31);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 16'h200B, 8'h00);
        checkOutput("ws3_c0_hold", SEL_HOLD, 32'd1);
        checkOutput("ws3_c0_busy", SEL_DO, 32'h00);
        checkOutput("ws3_bram", SEL_BRAM, 32'd1);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 16'h200B, 8'h00);
        checkOutput("ws3_c1_hold", SEL_HOLD, 32'd1);
        checkOutput("ws3_c1_busy", SEL_DO, 32'h80);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 16'h200B, 8'h00);
        checkOutput("ws3_c2_hold", SEL_HOLD, 32'd1);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 16'h200B, 8'h00);
        checkOutput("ws3_c3_hold", SEL_HOLD, 32'd0);
        checkOutput("ws3_c3_busy", SEL_DO, 32'h80);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 16'h200B, 8'h00);
        checkOutput("ws3_c4_hold", SEL_HOLD, 32'd0);
        checkOutput("ws3_c4_busy", SEL_DO, 32'h00);

        // WS = 0 never holds
        reg_write(5'd10, 8'h01);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 16'h2000, 8'h00);
            checkOutput("ws0_hold", SEL_HOLD, 32'd0);
        end

        // WS = 5 interrupted by asynchronous reset
        reg_write(5'd10, 8'h51);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 16'h2000, 8'h00);
        checkOutput("ws5_c0_hold", SEL_HOLD, 32'd1);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 16'h2000, 8'h00);
        checkOutput("ws5_c1_hold", SEL_HOLD, 32'd1);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 16'h2000, 8'h00);
        rst = 1'b0;
        checkOutput("arst_hold", SEL_HOLD, 32'd0);
        checkOutput("arst_bram", SEL_BRAM, 32'd0);
        reg_read("arst_page1", 5'd1, 8'h00);
        reg_read("arst_enable", 5'd8, 8'h00);
        reg_read("arst_wprot", 5'd9, 8'h00);
        reg_read("arst_ctrl", 5'd10, 8'h00);
        reg_read("arst_faddr_hi", 5'd12, 8'h00);
        @(posedge clk);
        #1 rst = 1'b1;

        // Unimplemented offsets
        reg_read("ff_off2", 5'd2, 8'hFF);
        reg_read("ff_off7", 5'd7, 8'hFF);
        reg_read("ff_off14", 5'd14, 8'hFF);
        reg_read("ff_off31", 5'd31, 8'hFF);

        // Wide instance: PAGE[3] = 31 at slot 5
        reg_write(5'd3, 8'd31);
        reg_write(5'd8, 8'h08);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 16'hBFFF, 8'h00);
        checkOutput("wide_ext_addr", SEL_EXTB, 32'h7FFFF);
        checkOutput("narrow_ext_addr", SEL_EXTA, 32'h0BFFF);

        bus_idle();
        repeat (2) @(posedge clk);
        if (sb.size() != 0) begin
            checks++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
